sevenseg_capture: RTL and testbench

- Receive end of the team's multiplexed seven-segment display interface.
- Snoops the active-low digit enables and segment lines, waits for a pattern to be stable, then decodes it back to a hex nibble per digit.
- Used on-board and in benches to read back what the CPU's display path actually shows, for self-check and debug-register readout.
- Sits beside the display driver on the same pins; never drives them.

---
 rtl/sevenseg_pkg.sv | 39 +++
 rtl/sevenseg_decode.sv | 36 +++
 rtl/sevenseg_capture.sv | 177 +++++++++++++++++
 tb/tb_sevenseg_capture.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and segment patterns for the seven-segment capture path.
package sevenseg_pkg;

  localparam int unsigned SEG_W = 7;

  // Active-low segment patterns, bit6..bit0 = g,f,e,d,c,b,a.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Stability tracker states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  // What a stable segment pattern turned out to be.
  typedef enum logic [1:0] {
    HEX     = 2'd0,
    BLANK   = 2'd1,
    INVALID = 2'd2
  } kind_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output logic [3:0]       nibble_c,
  output kind_t            kind_c
);

  // Map the active-low pattern onto a nibble, blank or invalid.
  always_comb begin
    nibble_c = 4'h0;
    kind_c   = HEX;
    case (seg_n)
      SEG_0:     nibble_c = 4'h0;
      SEG_1:     nibble_c = 4'h1;
      SEG_2:     nibble_c = 4'h2;
      SEG_3:     nibble_c = 4'h3;
      SEG_4:     nibble_c = 4'h4;
      SEG_5:     nibble_c = 4'h5;
      SEG_6:     nibble_c = 4'h6;
      SEG_7:     nibble_c = 4'h7;
      SEG_8:     nibble_c = 4'h8;
      SEG_9:     nibble_c = 4'h9;
      SEG_A:     nibble_c = 4'hA;
      SEG_B:     nibble_c = 4'hB;
      SEG_C:     nibble_c = 4'hC;
      SEG_D:     nibble_c = 4'hD;
      SEG_E:     nibble_c = 4'hE;
      SEG_F:     nibble_c = 4'hF;
      SEG_BLANK: kind_c   = BLANK;
      default:   kind_c   = INVALID;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Passive snooper for the multiplexed seven-segment bus: waits for a stable
// digit pattern and decodes it back to a hex nibble per digit.
// Optional decimal-point capture is enabled with SEVENSEG_CAPTURE_DP_EN.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     invalid_pat,
  output logic                  frame_done
`ifdef SEVENSEG_CAPTURE_DP_EN
  ,
  input  logic                  dp_n,
  output logic [DIGITS-1:0]     dp
`endif
);

`ifdef SEVENSEG_CAPTURE_DP_EN
  localparam int unsigned DP_W = 1;
`else
  localparam int unsigned DP_W = 0;
`endif
  localparam int unsigned SAMPLE_W = DIGITS + SEG_W + DP_W;

  logic [SAMPLE_W-1:0] pin_c;
  logic [SAMPLE_W-1:0] sync1;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] prev;
  logic [DIGITS-1:0]   an_s;
  logic [SEG_W-1:0]    seg_s;
  logic [DIGITS-1:0]   sel_mask;
  logic [DIGITS-1:0]   seen;
  logic [CNT_W-1:0]    cnt;
  state_t              state;
  logic                onehot;
  logic                changed;
  logic                capture;
  logic [3:0]          dec_nibble;
  kind_t               dec_kind;

`ifdef SEVENSEG_CAPTURE_DP_EN
  assign pin_c = {an_n, seg_n, dp_n};
`else
  assign pin_c = {an_n, seg_n};
`endif

  // Two-flop synchronizer; resets to the idle bus (all lines high).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1  <= '1;
      sample <= '1;
    end else begin
      sync1  <= pin_c;
      sample <= sync1;
    end
  end

  assign an_s     = sample[SAMPLE_W-1 -: DIGITS];
  assign seg_s    = sample[DP_W +: SEG_W];
  assign sel_mask = ~an_s;
  assign onehot   = $onehot(sel_mask);
  assign changed  = (sample != prev);

  // Capture fires on the sample that makes the run STABLE_CYCLES long.
  always_comb begin
    capture = 1'b0;
    if (state == TRACK && !changed && cnt == CNT_W'(STABLE_CYCLES - 1))
      capture = 1'b1;
  end

  sevenseg_decode u_decode (
    .seg_n    (seg_s),
    .nibble_c (dec_nibble),
    .kind_c   (dec_kind)
  );

  // Stability tracker: counts identical one-hot samples, saturating at capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= '1;
    end else begin
      prev <= sample;
      if (clear) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (onehot) begin
              state <= TRACK;
              cnt   <= CNT_W'(1);
            end
          end
          TRACK, HELD: begin
            if (changed) begin
              if (onehot) begin
                state <= TRACK;
                cnt   <= CNT_W'(1);
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end else if (capture) begin
              state <= HELD;
              cnt   <= CNT_W'(STABLE_CYCLES);
            end else if (state == TRACK && cnt < CNT_W'(STABLE_CYCLES)) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Per-digit capture registers and frame completion tracking.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value       <= '0;
      digit_valid <= '0;
      invalid_pat <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
`ifdef SEVENSEG_CAPTURE_DP_EN
      dp          <= '0;
`endif
    end else if (clear) begin
      value       <= '0;
      digit_valid <= '0;
      invalid_pat <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
`ifdef SEVENSEG_CAPTURE_DP_EN
      dp          <= '0;
`endif
    end else begin
      frame_done <= &seen;
      seen       <= ((&seen) ? '0 : seen) | (capture ? sel_mask : '0);
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (capture && sel_mask[i]) begin
          case (dec_kind)
            HEX: begin
              value[4*i +: 4] <= dec_nibble;
              digit_valid[i]  <= 1'b1;
              invalid_pat[i]  <= 1'b0;
            end
            BLANK: begin
              digit_valid[i]  <= 1'b0;
              invalid_pat[i]  <= 1'b0;
            end
            default: begin
              invalid_pat[i]  <= 1'b1;
            end
          endcase
`ifdef SEVENSEG_CAPTURE_DP_EN
          dp[i] <= ~sample[0];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed self-checking bench for sevenseg_capture (default build, no DP).
module tb_sevenseg_capture;
  import sevenseg_pkg::*;

  logic        clock;
  logic        resetn;
  logic        clear;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic [3:0]  invalid_pat;
  logic        frame_done;

  int tests;
  int failed;

  sevenseg_capture #(
    .DIGITS        (4),
    .STABLE_CYCLES (8),
    .CNT_W         (8)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .clear       (clear),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .value       (value),
    .digit_valid (digit_valid),
    .invalid_pat (invalid_pat),
    .frame_done  (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_and_clear();
    an_n  = 4'hF;
    seg_n = 7'h7F;
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    resetn = 1'b0;
    clear  = 1'b0;
    an_n   = 4'hF;
    seg_n  = 7'h7F;
    step(2);
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    check("reset_invalid", 32'(invalid_pat), 32'h0);
    check("reset_frame", 32'(frame_done), 32'h0);
    resetn = 1'b1;
    step(2);

    // Single digit: latency is exactly 2 + 8 cycles.
    an_n  = 4'b1110;
    seg_n = 7'h24;
    step(9);
    check("t1_pre_valid", 32'(digit_valid), 32'h0);
    step(1);
    check("t1_value", 32'(value), 32'h0002);
    check("t1_valid", 32'(digit_valid), 32'h1);
    check("t1_invalid", 32'(invalid_pat), 32'h0);
    step(2);
    check("t1_hold_value", 32'(value), 32'h0002);

    idle_and_clear();
    check("clr_value", 32'(value), 32'h0);
    check("clr_valid", 32'(digit_valid), 32'h0);

    // Full frame across four digits.
    an_n = 4'b1110; seg_n = 7'h30; step(10);
    check("t2_d0", 32'(value), 32'h0003);
    an_n = 4'b1101; seg_n = 7'h19; step(10);
    an_n = 4'b1011; seg_n = 7'h12; step(10);
    check("t2_d2_frame", 32'(frame_done), 32'h0);
    an_n = 4'b0111; seg_n = 7'h02; step(10);
    check("t2_value", 32'(value), 32'h6543);
    check("t2_valid", 32'(digit_valid), 32'hF);
    check("t2_frame_pre", 32'(frame_done), 32'h0);
    step(1);
    check("t2_frame_pulse", 32'(frame_done), 32'h1);
    step(1);
    check("t2_frame_end", 32'(frame_done), 32'h0);

    // Toggling faster than the stability window never captures.
    idle_and_clear();
    an_n = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      seg_n = 7'h40; step(5);
      seg_n = 7'h79; step(5);
    end
    seg_n = 7'h40; step(5);
    check("t3_toggle_valid", 32'(digit_valid), 32'h0);
    check("t3_toggle_value", 32'(value), 32'h0);
    seg_n = 7'h79; step(9);
    check("t3_pre_valid", 32'(digit_valid), 32'h0);
    step(1);
    check("t3_value", 32'(value), 32'h0010);
    check("t3_valid", 32'(digit_valid), 32'h2);

    // Invalid then blank on digit 2.
    an_n = 4'b1011; seg_n = 7'h0E; step(10);
    check("t4_f_value", 32'(value), 32'h0F10);
    check("t4_f_valid", 32'(digit_valid), 32'h6);
    seg_n = 7'h55; step(10);
    check("t4_inv_flag", 32'(invalid_pat), 32'h4);
    check("t4_inv_value", 32'(value), 32'h0F10);
    check("t4_inv_valid", 32'(digit_valid), 32'h6);
    seg_n = 7'h7F; step(10);
    check("t4_blank_valid", 32'(digit_valid), 32'h2);
    check("t4_blank_inv", 32'(invalid_pat), 32'h0);
    check("t4_blank_value", 32'(value), 32'h0F10);

    // Two enables low: stays idle, nothing changes.
    an_n = 4'b1100; seg_n = 7'h24; step(20);
    check("t5_state", 32'(dut.state), 32'(IDLE));
    check("t5_value", 32'(value), 32'h0F10);
    check("t5_valid", 32'(digit_valid), 32'h2);
    check("t5_invalid", 32'(invalid_pat), 32'h0);
    check("t5_frame", 32'(frame_done), 32'h0);

    // Clear on the capture edge discards that capture and restarts counting.
    idle_and_clear();
    an_n = 4'b1110; seg_n = 7'h24; step(9);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t6_clr_valid", 32'(digit_valid), 32'h0);
    check("t6_clr_value", 32'(value), 32'h0);
    check("t6_clr_frame", 32'(frame_done), 32'h0);
    step(7);
    check("t6_recount_pre", 32'(digit_valid), 32'h0);
    step(1);
    check("t6_recount_valid", 32'(digit_valid), 32'h1);
    check("t6_recount_value", 32'(value), 32'h0002);

    // Asynchronous reset in the middle of tracking.
    an_n = 4'b1011; seg_n = 7'h30; step(5);
    resetn = 1'b0;
    #2;
    check("t7_rst_value", 32'(value), 32'h0);
    check("t7_rst_valid", 32'(digit_valid), 32'h0);
    resetn = 1'b1;
    step(9);
    check("t7_pre_valid", 32'(digit_valid), 32'h0);
    step(1);
    check("t7_valid", 32'(digit_valid), 32'h4);
    check("t7_value", 32'(value), 32'h0300);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
